vending_fsm_param: RTL and testbench

//  Registered, parametrised vending controller; successor to the 7-state keypad vending FSM.

---
 rtl/vending_fsm_param_if.sv | 41 ++++
 rtl/vending_fsm_param.sv | 277 +++++++++++++++++++++++++++
 tb/tb_vending_fsm_param.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/vending_fsm_param_if.sv
// Keypad-to-controller bundle for vending_fsm_param.
// master: keypad/debounce side (drives key strobes, observes controller outputs).
// slave : vending controller (consumes key strobes, drives display/dispense/change).
// Signals:
//   key_vld      one-cycle strobe, key_code valid
//   key_code     debounced key code (1..7 product, 8/9/A coins, B cancel, C qty+, E accept, F OK)
//   state_o      current state code
//   disp_val_o   value for the D0..D2 display
//   dispense_o   one-cycle product release pulse
//   prod_id_o    selected product key
//   qty_o        selected quantity
//   change_o     change/refund amount, valid with change_vld_o
//   change_vld_o one-cycle change return pulse
//   coin_rej_o   one-cycle coin reject pulse
interface vending_fsm_param_if #(
    parameter int unsigned AMT_W = 8,
    parameter int unsigned QTY_W = 4
);
    logic             key_vld;
    logic [3:0]       key_code;
    logic [2:0]       state_o;
    logic [AMT_W-1:0] disp_val_o;
    logic             dispense_o;
    logic [2:0]       prod_id_o;
    logic [QTY_W-1:0] qty_o;
    logic [AMT_W-1:0] change_o;
    logic             change_vld_o;
    logic             coin_rej_o;

    modport master (
        output key_vld, key_code,
        input  state_o, disp_val_o, dispense_o, prod_id_o, qty_o,
               change_o, change_vld_o, coin_rej_o
    );

    modport slave (
        input  key_vld, key_code,
        output state_o, disp_val_o, dispense_o, prod_id_o, qty_o,
               change_o, change_vld_o, coin_rej_o
    );
endinterface

// File: rtl/vending_fsm_param.sv
// Parametrised, fully registered vending controller.
// Walks IDLE -> SELECT -> CONFIRM -> QTY -> TOTAL -> PAY -> DISPENSE -> CHANGE on
// debounced key strobes, with price table, wrapping quantity, cancel/refund,
// change return and coin overflow rejection.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-low reset
//   bus    vending_fsm_param_if.slave (key strobe in, display/dispense/change out)
// Optional feature: define VEND_TIMEOUT_EN to enable the inactivity timeout
// (TO_CYCLES idle cycles in SELECT..PAY act as a cancel).
module vending_fsm_param #(
    parameter int unsigned                N_PROD     = 5,
    parameter int unsigned                AMT_W      = 8,
    parameter int unsigned                QTY_W      = 4,
    parameter int unsigned                MAX_QTY    = 3,
    parameter logic [N_PROD*AMT_W-1:0]    PRICE_LIST = {8'd1, 8'd2, 8'd5, 8'd10, 8'd6},
    parameter int unsigned                TO_CYCLES  = 1000000
) (
    input logic                 clk,
    input logic                 reset,
    vending_fsm_param_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SELECT   = 3'd1,
        S_CONFIRM  = 3'd2,
        S_QTY      = 3'd3,
        S_TOTAL    = 3'd4,
        S_PAY      = 3'd5,
        S_DISPENSE = 3'd6,
        S_CHANGE   = 3'd7
    } state_t;

    localparam logic [3:0] KEY_COIN1  = 4'h8;
    localparam logic [3:0] KEY_COIN5  = 4'h9;
    localparam logic [3:0] KEY_COIN10 = 4'hA;
    localparam logic [3:0] KEY_CANCEL = 4'hB;
    localparam logic [3:0] KEY_QTY    = 4'hC;
    localparam logic [3:0] KEY_ACCEPT = 4'hE;
    localparam logic [3:0] KEY_OK     = 4'hF;

    state_t           state_q, state_d;
    logic [AMT_W-1:0] price_q, price_d;
    logic [QTY_W-1:0] qty_q, qty_d;
    logic [AMT_W-1:0] total_q, total_d;
    logic [AMT_W-1:0] paid_q, paid_d;
    logic             ovf_q, ovf_d;
    logic [2:0]       prod_q, prod_d;
    logic [AMT_W-1:0] disp_q, disp_d;
    logic             dispense_q, dispense_d;
    logic [AMT_W-1:0] change_q, change_d;
    logic             change_vld_q, change_vld_d;
    logic             coin_rej_q, coin_rej_d;

    logic                   cancel;
    logic                   is_coin;
    logic [AMT_W-1:0]       coin;
    logic [AMT_W:0]         pay_sum;
    logic [AMT_W+QTY_W-1:0] mult;
    logic                   to_hit;

    function automatic logic [AMT_W-1:0] price_of(input logic [3:0] k);
        logic [AMT_W-1:0] p;
        p = '0;
        for (int unsigned i = 0; i < N_PROD; i++) begin
            if (k == 4'(i + 1)) p = PRICE_LIST[i*AMT_W +: AMT_W];
        end
        return p;
    endfunction

    always_comb begin
        is_coin = 1'b1;
        coin    = '0;
        case (bus.key_code)
            KEY_COIN1:  coin = AMT_W'(1);
            KEY_COIN5:  coin = AMT_W'(5);
            KEY_COIN10: coin = AMT_W'(10);
            default:    is_coin = 1'b0;
        endcase
    end

    // One extra bit so a sum beyond the money range is detectable.
    assign pay_sum = {1'b0, paid_q} + {1'b0, coin};
    assign mult    = (AMT_W+QTY_W)'(price_q) * (AMT_W+QTY_W)'(qty_q);

`ifdef VEND_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TO_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q;

    assign to_hit = (to_cnt_q == TO_W'(TO_CYCLES));

    // Cleared by any key and on every state change; saturates at TO_CYCLES.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt_q <= '0;
        end else if (bus.key_vld || (state_d != state_q)) begin
            to_cnt_q <= '0;
        end else if (!to_hit) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        price_d      = price_q;
        qty_d        = qty_q;
        total_d      = total_q;
        paid_d       = paid_q;
        ovf_d        = ovf_q;
        prod_d       = prod_q;
        dispense_d   = 1'b0;
        change_d     = '0;
        change_vld_d = 1'b0;
        coin_rej_d   = 1'b0;
        cancel       = 1'b0;
        disp_d       = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.key_vld && bus.key_code == KEY_OK) state_d = S_SELECT;
            end
            S_SELECT: begin
                if (bus.key_vld) begin
                    if (bus.key_code == KEY_CANCEL) begin
                        cancel = 1'b1;
                    end else if (bus.key_code >= 4'd1 && bus.key_code <= 4'(N_PROD)) begin
                        price_d = price_of(bus.key_code);
                        prod_d  = bus.key_code[2:0];
                        state_d = S_CONFIRM;
                    end
                end
            end
            S_CONFIRM: begin
                if (bus.key_vld) begin
                    if (bus.key_code == KEY_CANCEL) begin
                        cancel = 1'b1;
                    end else if (bus.key_code == KEY_OK) begin
                        qty_d   = QTY_W'(1);
                        state_d = S_QTY;
                    end
                end
            end
            S_QTY: begin
                if (bus.key_vld) begin
                    if (bus.key_code == KEY_CANCEL) begin
                        cancel = 1'b1;
                    end else if (bus.key_code == KEY_QTY) begin
                        qty_d = (qty_q == QTY_W'(MAX_QTY)) ? QTY_W'(1) : qty_q + QTY_W'(1);
                    end else if (bus.key_code == KEY_OK) begin
                        // Total is fixed on entry; an oversized product locks TOTAL until cancel.
                        if (mult[AMT_W+QTY_W-1:AMT_W] != '0) begin
                            total_d = '1;
                            ovf_d   = 1'b1;
                        end else begin
                            total_d = mult[AMT_W-1:0];
                            ovf_d   = 1'b0;
                        end
                        state_d = S_TOTAL;
                    end
                end
            end
            S_TOTAL: begin
                if (bus.key_vld) begin
                    if (bus.key_code == KEY_CANCEL) begin
                        cancel = 1'b1;
                    end else if (bus.key_code == KEY_ACCEPT && !ovf_q) begin
                        paid_d  = '0;
                        state_d = S_PAY;
                    end
                end
            end
            S_PAY: begin
                if (bus.key_vld) begin
                    if (bus.key_code == KEY_CANCEL) begin
                        cancel = 1'b1;
                    end else if (is_coin) begin
                        if (pay_sum[AMT_W]) coin_rej_d = 1'b1;
                        else                paid_d     = pay_sum[AMT_W-1:0];
                    end else if (bus.key_code == KEY_OK && paid_q >= total_q) begin
                        dispense_d = 1'b1;
                        state_d    = S_DISPENSE;
                    end
                end
            end
            S_DISPENSE: begin
                if (bus.key_vld && bus.key_code == KEY_OK) begin
                    change_d     = paid_q - total_q;
                    change_vld_d = 1'b1;
                    state_d      = S_CHANGE;
                end
            end
            S_CHANGE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (to_hit && !bus.key_vld &&
            (state_q == S_SELECT || state_q == S_CONFIRM || state_q == S_QTY ||
             state_q == S_TOTAL  || state_q == S_PAY)) begin
            cancel = 1'b1;
        end

        if (cancel) begin
            state_d = S_IDLE;
            if (paid_q != '0) begin
                change_d     = paid_q;
                change_vld_d = 1'b1;
            end
        end

        if (state_d == S_IDLE) begin
            price_d = '0;
            qty_d   = '0;
            total_d = '0;
            paid_d  = '0;
            ovf_d   = 1'b0;
            prod_d  = '0;
        end

        case (state_d)
            S_CONFIRM:  disp_d = price_d;
            S_QTY:      disp_d = AMT_W'(qty_d);
            S_TOTAL:    disp_d = total_d;
            S_PAY:      disp_d = paid_d;
            S_DISPENSE: disp_d = paid_d;
            S_CHANGE:   disp_d = change_d;
            default:    disp_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            price_q      <= '0;
            qty_q        <= '0;
            total_q      <= '0;
            paid_q       <= '0;
            ovf_q        <= 1'b0;
            prod_q       <= '0;
            disp_q       <= '0;
            dispense_q   <= 1'b0;
            change_q     <= '0;
            change_vld_q <= 1'b0;
            coin_rej_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            price_q      <= price_d;
            qty_q        <= qty_d;
            total_q      <= total_d;
            paid_q       <= paid_d;
            ovf_q        <= ovf_d;
            prod_q       <= prod_d;
            disp_q       <= disp_d;
            dispense_q   <= dispense_d;
            change_q     <= change_d;
            change_vld_q <= change_vld_d;
            coin_rej_q   <= coin_rej_d;
        end
    end

    assign bus.state_o      = state_q;
    assign bus.disp_val_o   = disp_q;
    assign bus.dispense_o   = dispense_q;
    assign bus.prod_id_o    = prod_q;
    assign bus.qty_o        = qty_q;
    assign bus.change_o     = change_q;
    assign bus.change_vld_o = change_vld_q;
    assign bus.coin_rej_o   = coin_rej_q;

endmodule

// File: tb/tb_vending_fsm_param.sv
// Directed bench for vending_fsm_param: a table of one-cycle key vectors with
// hand-computed outputs, plus hand-written overflow, cancel and reset sequences.
module tb_vending_fsm_param;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    vending_fsm_param_if #(.AMT_W(8), .QTY_W(4)) bus ();

    vending_fsm_param #(
        .N_PROD    (5),
        .AMT_W     (8),
        .QTY_W     (4),
        .MAX_QTY   (3),
        .PRICE_LIST({8'd1, 8'd2, 8'd5, 8'd10, 8'd6}),
        .TO_CYCLES (16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        logic [3:0] key;
        logic [2:0] st;
        logic [7:0] disp;
        logic       dsp;
        logic [2:0] prod;
        logic [3:0] qty;
        logic [7:0] chg;
        logic       cvld;
        logic       rej;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    // Drive one key (or none) for exactly one cycle; returns at the following negedge.
    task automatic step(input logic vld, input logic [3:0] k);
        bus.key_vld  = vld;
        bus.key_code = k;
        @(negedge clk);
    endtask

    task automatic press(input logic [3:0] k);
        step(1'b1, k);
    endtask

    task automatic add(input logic v, input logic [3:0] k, input int st, input int disp,
                       input logic dsp, input int prod, input int qty, input int chg,
                       input logic cvld, input logic rej);
        vec_t e;
        e.vld = v; e.key = k; e.st = 3'(st); e.disp = 8'(disp); e.dsp = dsp;
        e.prod = 3'(prod); e.qty = 4'(qty); e.chg = 8'(chg); e.cvld = cvld; e.rej = rej;
        vq.push_back(e);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        bus.key_vld  = 1'b0;
        bus.key_code = 4'h0;

        //  vld  key   st disp dsp prod qty chg cvld rej
        // Product 2 (price 10), qty 2 -> total 20; exact payment, zero change.
        add(1, 4'hF, 1,  0, 0, 0, 0, 0, 0, 0);
        add(1, 4'h2, 2, 10, 0, 2, 0, 0, 0, 0);
        add(1, 4'hF, 3,  1, 0, 2, 1, 0, 0, 0);
        add(1, 4'hC, 3,  2, 0, 2, 2, 0, 0, 0);
        add(1, 4'hF, 4, 20, 0, 2, 2, 0, 0, 0);
        add(1, 4'hE, 5,  0, 0, 2, 2, 0, 0, 0);
        add(1, 4'hA, 5, 10, 0, 2, 2, 0, 0, 0);
        add(1, 4'hF, 5, 10, 0, 2, 2, 0, 0, 0);
        add(1, 4'hA, 5, 20, 0, 2, 2, 0, 0, 0);
        add(1, 4'hF, 6, 20, 1, 2, 2, 0, 0, 0);
        add(0, 4'hF, 6, 20, 0, 2, 2, 0, 0, 0);
        add(1, 4'hF, 7,  0, 0, 2, 2, 0, 1, 0);
        add(0, 4'h0, 0,  0, 0, 0, 0, 0, 0, 0);
        // Product 3 (price 5), coins 1+10 -> change 6.
        add(1, 4'hF, 1,  0, 0, 0, 0, 0, 0, 0);
        add(1, 4'h3, 2,  5, 0, 3, 0, 0, 0, 0);
        add(1, 4'hF, 3,  1, 0, 3, 1, 0, 0, 0);
        add(1, 4'hF, 4,  5, 0, 3, 1, 0, 0, 0);
        add(1, 4'hE, 5,  0, 0, 3, 1, 0, 0, 0);
        add(1, 4'h8, 5,  1, 0, 3, 1, 0, 0, 0);
        add(1, 4'hA, 5, 11, 0, 3, 1, 0, 0, 0);
        add(1, 4'hF, 6, 11, 1, 3, 1, 0, 0, 0);
        add(1, 4'hF, 7,  6, 0, 3, 1, 6, 1, 0);
        add(0, 4'h0, 0,  0, 0, 0, 0, 0, 0, 0);
        // Coin and cancel in IDLE are ignored.
        add(1, 4'h9, 0,  0, 0, 0, 0, 0, 0, 0);
        add(1, 4'hB, 0,  0, 0, 0, 0, 0, 0, 0);
        // Quantity wrap 1,2,3,1; stray key ignored; cancel with nothing paid.
        add(1, 4'hF, 1,  0, 0, 0, 0, 0, 0, 0);
        add(1, 4'h1, 2,  6, 0, 1, 0, 0, 0, 0);
        add(1, 4'hF, 3,  1, 0, 1, 1, 0, 0, 0);
        add(1, 4'hC, 3,  2, 0, 1, 2, 0, 0, 0);
        add(1, 4'hC, 3,  3, 0, 1, 3, 0, 0, 0);
        add(1, 4'hC, 3,  1, 0, 1, 1, 0, 0, 0);
        add(1, 4'h7, 3,  1, 0, 1, 1, 0, 0, 0);
        add(1, 4'hB, 0,  0, 0, 0, 0, 0, 0, 0);
        // Product key above N_PROD ignored in SELECT.
        add(1, 4'hF, 1,  0, 0, 0, 0, 0, 0, 0);
        add(1, 4'h6, 1,  0, 0, 0, 0, 0, 0, 0);
        add(1, 4'hB, 0,  0, 0, 0, 0, 0, 0, 0);

        repeat (2) @(negedge clk);
        chk("rst_state", 0, int'(bus.state_o), 0);
        chk("rst_disp", 0, int'(bus.disp_val_o), 0);
        chk("rst_dispense", 0, int'(bus.dispense_o), 0);
        chk("rst_prod", 0, int'(bus.prod_id_o), 0);
        chk("rst_qty", 0, int'(bus.qty_o), 0);
        chk("rst_change", 0, int'(bus.change_o), 0);
        chk("rst_change_vld", 0, int'(bus.change_vld_o), 0);
        chk("rst_coin_rej", 0, int'(bus.coin_rej_o), 0);
        reset = 1'b1;
        @(negedge clk);

        foreach (vq[i]) begin
            step(vq[i].vld, vq[i].key);
            chk("state", i, int'(bus.state_o), int'(vq[i].st));
            chk("disp", i, int'(bus.disp_val_o), int'(vq[i].disp));
            chk("dispense", i, int'(bus.dispense_o), int'(vq[i].dsp));
            chk("prod", i, int'(bus.prod_id_o), int'(vq[i].prod));
            chk("qty", i, int'(bus.qty_o), int'(vq[i].qty));
            if (vq[i].cvld) chk("change", i, int'(bus.change_o), int'(vq[i].chg));
            chk("change_vld", i, int'(bus.change_vld_o), int'(vq[i].cvld));
            chk("coin_rej", i, int'(bus.coin_rej_o), int'(vq[i].rej));
        end
        step(1'b0, 4'h0);

        // Coin overflow: product 4 (price 2), pay 25 x 10 = 250, then 10 rejected, 1 accepted.
        press(4'hF); press(4'h4); press(4'hF); press(4'hF); press(4'hE);
        chk("ovf_in_pay", 0, int'(bus.state_o), 5);
        for (int i = 0; i < 25; i++) press(4'hA);
        chk("ovf_paid250", 0, int'(bus.disp_val_o), 250);
        press(4'hA);
        chk("ovf_rej", 0, int'(bus.coin_rej_o), 1);
        chk("ovf_paid_held", 0, int'(bus.disp_val_o), 250);
        step(1'b0, 4'h0);
        chk("ovf_rej_pulse", 0, int'(bus.coin_rej_o), 0);
        press(4'h8);
        chk("ovf_paid251", 0, int'(bus.disp_val_o), 251);
        chk("ovf_no_rej", 0, int'(bus.coin_rej_o), 0);
        press(4'hB);
        chk("ovf_refund", 0, int'(bus.change_o), 251);
        chk("ovf_refund_vld", 0, int'(bus.change_vld_o), 1);
        chk("ovf_refund_idle", 0, int'(bus.state_o), 0);
        step(1'b0, 4'h0);
        chk("ovf_refund_pulse", 0, int'(bus.change_vld_o), 0);

        // Cancel in PAY with 6 paid.
        press(4'hF); press(4'h1); press(4'hF); press(4'hF); press(4'hE);
        press(4'h9); press(4'h8);
        chk("cancel_paid", 0, int'(bus.disp_val_o), 6);
        press(4'hB);
        chk("cancel_change", 0, int'(bus.change_o), 6);
        chk("cancel_vld", 0, int'(bus.change_vld_o), 1);
        chk("cancel_state", 0, int'(bus.state_o), 0);
        step(1'b0, 4'h0);

        // Reset low in PAY: immediate IDLE, no refund pulse.
        press(4'hF); press(4'h1); press(4'hF); press(4'hF); press(4'hE); press(4'h9);
        chk("rstpay_paid", 0, int'(bus.disp_val_o), 5);
        bus.key_vld = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("rstpay_state", 0, int'(bus.state_o), 0);
        chk("rstpay_disp", 0, int'(bus.disp_val_o), 0);
        chk("rstpay_vld", 0, int'(bus.change_vld_o), 0);
        @(negedge clk);
        reset = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 4; i++) begin
                step(1'b0, 4'h0);
                if (bus.change_vld_o) seen++;
            end
            chk("rstpay_no_pulse", 0, seen, 0);
            chk("rstpay_idle", 0, int'(bus.state_o), 0);
        end

`ifdef VEND_TIMEOUT_EN
        // Inactivity in PAY with 5 paid refunds and returns to IDLE.
        press(4'hF); press(4'h1); press(4'hF); press(4'hF); press(4'hE); press(4'h9);
        begin
            int got;
            got = 0;
            for (int i = 0; i < 40 && got == 0; i++) begin
                step(1'b0, 4'h0);
                if (bus.change_vld_o) begin
                    got = 1;
                    chk("to_refund", 0, int'(bus.change_o), 5);
                    chk("to_state", 0, int'(bus.state_o), 0);
                end
            end
            chk("to_fired", 0, got, 1);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
